// File: rtl/lfsr_scrambler_par.sv
// rtl/lfsr_scrambler_par.sv - parallel LFSR scrambler/descrambler, DATA_W bits per beat
// Additive or self-synchronising mode, single output register stage with valid/ready.
module lfsr_scrambler_par #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY   = 7'h60,
  parameter logic [LFSR_W-1:0] SEED   = 7'h7F,
  parameter int                MODE   = 0,
  parameter int                DESCR  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic [LFSR_W-1:0] scr_state;
  logic [DATA_W-1:0] scr_data;
  logic              fb;
  logic              shift_in;
  logic              accept;

  // Unrolled bit-serial recurrence: bit 0 sees the current state, bit DATA_W-1 the most advanced.
  always_comb begin
    scr_state = state_q;
    scr_data  = '0;
    fb        = 1'b0;
    shift_in  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb          = ^(scr_state & POLY);
      scr_data[i] = s_data_i[i] ^ fb;
      if (MODE == 0)
        shift_in = fb;
      else if (DESCR == 0)
        shift_in = scr_data[i];
      else
        shift_in = s_data_i[i];
      scr_state = {scr_state[LFSR_W-2:0], shift_in};
    end
  end

  assign s_ready_o = ~rst_i & ~seed_load_i & (~m_valid_q | m_ready_i);
  assign accept    = s_valid_i & s_ready_o;

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (seed_load_i) begin
      // An all-zero additive LFSR would never leave zero, so fall back to SEED.
      if (MODE == 0 && seed_i == '0)
        state_d = SEED;
      else
        state_d = seed_i;
    end else if (accept) begin
      state_d = scr_state;
    end
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = scr_data;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEED;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// tb/tb_lfsr_scrambler_par.sv - self-checking bench for lfsr_scrambler_par
// Additive 8-bit loopback, 1-bit serial golden comparison, multiplicative error propagation.
module tb_lfsr_scrambler_par;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // additive chain a -> b
  logic       a_seed_load;
  logic [6:0] a_seed;
  logic       a_sv, a_sr, a_mv;
  logic [7:0] a_sd, a_md;
  logic [6:0] a_st;
  logic       b_sr, b_mv, b_mr;
  logic [7:0] b_md;
  logic [6:0] b_st;

  lfsr_scrambler_par u_a (
    .clk_i(clk), .rst_i(rst), .seed_load_i(a_seed_load), .seed_i(a_seed),
    .s_valid_i(a_sv), .s_ready_o(a_sr), .s_data_i(a_sd),
    .m_valid_o(a_mv), .m_ready_i(b_sr), .m_data_o(a_md), .state_o(a_st));

  lfsr_scrambler_par u_b (
    .clk_i(clk), .rst_i(rst), .seed_load_i(1'b0), .seed_i(7'h00),
    .s_valid_i(a_mv), .s_ready_o(b_sr), .s_data_i(a_md),
    .m_valid_o(b_mv), .m_ready_i(b_mr), .m_data_o(b_md), .state_o(b_st));

  // 1-bit serial instance
  logic       s_sv, s_sr, s_mv;
  logic [0:0] s_sd, s_md;
  logic [6:0] s_st;

  lfsr_scrambler_par #(.DATA_W(1)) u_s (
    .clk_i(clk), .rst_i(rst), .seed_load_i(1'b0), .seed_i(7'h00),
    .s_valid_i(s_sv), .s_ready_o(s_sr), .s_data_i(s_sd),
    .m_valid_o(s_mv), .m_ready_i(1'b1), .m_data_o(s_md), .state_o(s_st));

  // multiplicative chain ms -> (bit flip) -> md
  logic       ms_sv, ms_sr, ms_mv, md_sr, md_mv, md_mr;
  logic [7:0] ms_sd, ms_md, md_sd, md_md, flip;
  logic [6:0] ms_st, md_st;
  assign md_sd = ms_md ^ flip;

  lfsr_scrambler_par #(.MODE(1), .DESCR(0)) u_ms (
    .clk_i(clk), .rst_i(rst), .seed_load_i(1'b0), .seed_i(7'h00),
    .s_valid_i(ms_sv), .s_ready_o(ms_sr), .s_data_i(ms_sd),
    .m_valid_o(ms_mv), .m_ready_i(md_sr), .m_data_o(ms_md), .state_o(ms_st));

  lfsr_scrambler_par #(.MODE(1), .DESCR(1)) u_md (
    .clk_i(clk), .rst_i(rst), .seed_load_i(1'b0), .seed_i(7'h00),
    .s_valid_i(ms_mv), .s_ready_o(md_sr), .s_data_i(md_sd),
    .m_valid_o(md_mv), .m_ready_i(md_mr), .m_data_o(md_md), .state_o(md_st));

  logic [7:0] q[$];
  logic [7:0] cur, d[12];
  logic [6:0] hist;
  logic       acc, dout, stall, fbit, ebit;
  int         sent, recv, cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_seed_load = 1'b0; a_seed = 7'h00; a_sv = 1'b0; a_sd = 8'h00; b_mr = 1'b1;
    s_sv = 1'b0; s_sd = 1'b0; ms_sv = 1'b0; ms_sd = 8'h00; md_mr = 1'b1; flip = 8'h00;
    tick(); tick();
    chk("rst_state", a_st, 7'h7F);
    chk("rst_mvalid", a_mv, 1'b0);
    chk("rst_mdata", a_md, 8'h00);
    chk("rst_sready", a_sr, 1'b0);
    chk("rst_state_ser", s_st, 7'h7F);
    chk("rst_state_ms", ms_st, 7'h7F);
    chk("rst_state_md", md_st, 7'h7F);

    // first beat of 0x00 from reset
    rst = 1'b0; a_sv = 1'b1; a_sd = 8'h00;
    #1 chk("first_sready", a_sr, 1'b1);
    tick();
    a_sv = 1'b0;
    chk("first_mdata", a_md, 8'h40);
    chk("first_mvalid", a_mv, 1'b1);
    chk("first_state", a_st, 7'h02);
    tick();
    chk("first_descr_data", b_md, 8'h00);
    chk("first_descr_valid", b_mv, 1'b1);
    chk("first_descr_state", b_st, 7'h02);
    chk("first_drained", a_mv, 1'b0);

    // zero seed load during valid data
    a_sv = 1'b1; a_sd = 8'hA5; a_seed_load = 1'b1; a_seed = 7'h00;
    #1 chk("seed_sready", a_sr, 1'b0);
    tick();
    chk("seed_state", a_st, 7'h7F);
    chk("seed_no_accept", a_mv, 1'b0);
    a_seed_load = 1'b0;
    #1 chk("seed_resume_sready", a_sr, 1'b1);
    tick();
    a_sv = 1'b0;
    chk("seed_resume_data", a_md, 8'hE5);
    chk("seed_resume_state", a_st, 7'h02);
    chk("seed_resume_valid", a_mv, 1'b1);

    // reset while a beat is held
    rst = 1'b1;
    tick();
    chk("midrst_mvalid", a_mv, 1'b0);
    chk("midrst_mdata", a_md, 8'h00);
    chk("midrst_state", a_st, 7'h7F);
    tick();
    rst = 1'b0;

    // additive loopback with random stalls
    sent = 0; recv = 0; cyc = 0;
    while (recv < 256 && cyc < 4000) begin
      a_sv = (sent < 256) && ($urandom_range(0, 3) != 0);
      a_sd = 8'($urandom);
      b_mr = ($urandom_range(0, 2) != 0);
      #1;
      acc = a_sv & a_sr; dout = b_mv & b_mr; stall = b_mv & ~b_mr; cur = b_md;
      if (acc) begin q.push_back(a_sd); sent++; end
      tick();
      if (dout) begin
        if (q.size() == 0) chk("loop_extra_beat", 32'd1, 32'd0);
        else chk("loop_data", cur, q.pop_front());
        recv++;
      end
      if (stall) chk("loop_stall_stable", b_md, cur);
      cyc++;
    end
    a_sv = 1'b0; b_mr = 1'b1;
    chk("loop_recv_count", recv, 256);
    chk("loop_queue_empty", q.size(), 0);

    // DATA_W=1 against a serial golden scrambler
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    hist = 7'h7F;
    for (int n = 0; n < 1001; n++) begin
      s_sv = (n < 1000);
      s_sd = 1'($urandom);
      #1;
      acc = s_sv & s_sr; dout = s_mv; cur = {7'b0, s_md};
      if (acc) begin
        fbit = hist[5] ^ hist[6];
        ebit = s_sd[0] ^ fbit;
        hist = {hist[5:0], fbit};
        q.push_back({7'b0, ebit});
      end
      tick();
      if (dout) chk("serial_bit", cur, (q.size() != 0) ? q.pop_front() : 8'hFF);
    end
    s_sv = 1'b0;
    chk("serial_queue_empty", q.size(), 0);

    // multiplicative: one flipped line bit corrupts bit j, j+6, j+7 then recovers
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    for (int k = 0; k < 12; k++) d[k] = 8'($urandom);
    for (int k = 0; k < 14; k++) begin
      ms_sv = (k < 12);
      ms_sd = (k < 12) ? d[k] : 8'h00;
      flip  = (k == 5) ? 8'h04 : 8'h00;
      #1;
      acc = ms_sv & ms_sr; dout = md_mv; cur = md_md;
      if (acc) q.push_back(d[k] ^ ((k == 4) ? 8'h04 : (k == 5) ? 8'h03 : 8'h00));
      tick();
      if (dout) chk("mult_data", cur, (q.size() != 0) ? q.pop_front() : 8'hXX);
    end
    ms_sv = 1'b0; flip = 8'h00;
    chk("mult_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
